// File: rtl/sequential_subtractor_64b_if.sv
// Handshake and operand/result bundle for the chunked subtractor.
// The master side issues operations and the slave side computes them.
interface sequential_subtractor_64b_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             BOUT;
  logic             ZERO;
  logic             OVF;

  modport master (
    output start, A, B, BIN,
    input  busy, done, D, BOUT, ZERO, OVF
  );

  modport slave (
    input  start, A, B, BIN,
    output busy, done, D, BOUT, ZERO, OVF
  );
endinterface

// File: rtl/sequential_subtractor_64b.sv
// Multi-cycle subtractor: D = A - B - BIN, CHUNK bits per clock, LSB chunk first.
// The borrow ripples between chunks through a registered flag.
module sequential_subtractor_64b #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input logic                        clk,
  input logic                        reset,
  sequential_subtractor_64b_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  stateT                        stateQ, stateD;
  logic [NCHUNK-1:0][CHUNK-1:0] aQ, aD;
  logic [NCHUNK-1:0][CHUNK-1:0] bQ, bD;
  logic [NCHUNK-1:0][CHUNK-1:0] dQ, dD;
  logic [CntW-1:0]              cntQ, cntD;
  logic                         borrowQ, borrowD;
  logic                         boutQ, boutD;
  logic                         zeroQ, zeroD;
  logic                         ovfQ, ovfD;
  logic [CHUNK:0]               chunkSum;

  always_comb begin
    stateD  = stateQ;
    aD      = aQ;
    bD      = bQ;
    dD      = dQ;
    cntD    = cntQ;
    borrowD = borrowQ;
    boutD   = boutQ;
    zeroD   = zeroQ;
    ovfD    = ovfQ;
    // A - B - borrow as A + ~B + ~borrow; the carry out is the inverted borrow.
    chunkSum = {1'b0, aQ[cntQ]} + {1'b0, ~bQ[cntQ]} + {{CHUNK{1'b0}}, ~borrowQ};

    unique case (stateQ)
      StIdle, StDone: begin
        if (bus.start) begin
          aD      = bus.A;
          bD      = bus.B;
          borrowD = bus.BIN;
          cntD    = '0;
          dD      = '0;
          stateD  = StRun;
        end else begin
          stateD  = StIdle;
        end
      end
      StRun: begin
        dD[cntQ] = chunkSum[CHUNK-1:0];
        borrowD  = ~chunkSum[CHUNK];
        cntD     = cntQ + CntW'(1);
        if (cntQ == LastCnt) begin
          stateD = StDone;
          boutD  = ~chunkSum[CHUNK];
          zeroD  = (dD == '0);
          ovfD   = (aQ[NCHUNK-1][CHUNK-1] != bQ[NCHUNK-1][CHUNK-1]) &&
                   (dD[NCHUNK-1][CHUNK-1] != aQ[NCHUNK-1][CHUNK-1]);
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ  <= StIdle;
      aQ      <= '0;
      bQ      <= '0;
      dQ      <= '0;
      cntQ    <= '0;
      borrowQ <= 1'b0;
      boutQ   <= 1'b0;
      zeroQ   <= 1'b0;
      ovfQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      aQ      <= aD;
      bQ      <= bD;
      dQ      <= dD;
      cntQ    <= cntD;
      borrowQ <= borrowD;
      boutQ   <= boutD;
      zeroQ   <= zeroD;
      ovfQ    <= ovfD;
    end
  end

  assign bus.busy = (stateQ == StRun);
  assign bus.done = (stateQ == StDone);
  assign bus.D    = dQ;
  assign bus.BOUT = boutQ;
  assign bus.ZERO = zeroQ;
  assign bus.OVF  = ovfQ;

endmodule
